// File: rtl/sdram_cmd_sched.sv
// Single-requester SDRAM command scheduler with per-bank open-row tracking.
// Optional periodic refresh is compiled in with `define SDRAM_SCHED_REFRESH_EN.
module sdram_cmd_sched #(
  parameter int T_RP         = 2,
  parameter int T_RCD        = 2,
  parameter int T_CL         = 1,
  parameter int REF_INTERVAL = 780,
  parameter int T_RFC        = 8
) (
  input  logic        ck,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [27:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        mem_en,
  output logic [2:0]  mem_ba,
  output logic [14:0] mem_row,
  output logic [9:0]  mem_col,
  output logic        mem_we_n,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  bank_open,
  output logic        ref_busy
);

  localparam int T_MAX_A = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int T_MAX_B = (T_CL > T_RFC) ? T_CL : T_RFC;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int TMR_W   = $clog2(T_MAX) + 1;

  typedef enum logic [2:0] {IDLE, PRE, ACT, ACCESS, RD_WAIT, REFRESH} state_t;

  // state_q is the FSM state that checkers bind to.
  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;

  logic               lat_we;
  logic [2:0]         lat_ba;
  logic [14:0]        lat_row;
  logic [9:0]         lat_col;
  logic [7:0]         lat_wdata;
  logic [14:0]        open_row [8];

  logic [2:0]         req_ba;
  logic [14:0]        req_row;
  logic [9:0]         req_col;
  logic               accept, row_hit, ref_pending, ref_enter;
  logic               access_enter, act_done, rd_done;

  // Handshake: a request transfers on the rising edge where req_valid && req_ready;
  // req_ready depends only on state, so it never combinationally follows req_valid.
  assign req_ready = (state_q == IDLE) && !ref_pending && !rst;
  assign accept    = req_valid && req_ready;
  assign req_ba    = req_addr[27:25];
  assign req_row   = req_addr[24:10];
  assign req_col   = req_addr[9:0];
  assign row_hit   = bank_open[req_ba] && (open_row[req_ba] == req_row);

  assign access_enter = (state_d == ACCESS) && (state_q != ACCESS);
  assign act_done     = (state_q == ACT) && (tmr_q == '0);
  assign rd_done      = (state_q == RD_WAIT) && (tmr_q == '0);
  assign ref_enter    = (state_q == IDLE) && (state_d == REFRESH);

  assign mem_en   = (state_q == ACCESS);
  assign mem_we_n = !((state_q == ACCESS) && lat_we);
  assign ref_busy = (state_q == REFRESH);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = (tmr_q != '0) ? tmr_q - 1'b1 : tmr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (row_hit) begin
            state_d = ACCESS;
          end else if (bank_open[req_ba]) begin
            state_d = PRE;
            tmr_d   = TMR_W'(T_RP - 1);
          end else begin
            state_d = ACT;
            tmr_d   = TMR_W'(T_RCD - 1);
          end
        end else if (ref_pending) begin
          state_d = REFRESH;
          tmr_d   = TMR_W'(T_RFC - 1);
        end
      end
      PRE: begin
        if (tmr_q == '0) begin
          state_d = ACT;
          tmr_d   = TMR_W'(T_RCD - 1);
        end
      end
      ACT: begin
        if (tmr_q == '0) state_d = ACCESS;
      end
      ACCESS: begin
        if (lat_we) begin
          state_d = IDLE;
        end else begin
          state_d = RD_WAIT;
          tmr_d   = TMR_W'(T_CL - 1);
        end
      end
      RD_WAIT: begin
        if (tmr_q == '0) state_d = IDLE;
      end
      REFRESH: begin
        if (tmr_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_ba    <= '0;
      lat_row   <= '0;
      lat_col   <= '0;
      lat_wdata <= '0;
      mem_ba    <= '0;
      mem_row   <= '0;
      mem_col   <= '0;
      mem_wdata <= '0;
      bank_open <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      for (int i = 0; i < 8; i++) open_row[i] <= '0;
    end else begin
      rsp_valid <= rd_done;
      if (rd_done) rsp_rdata <= mem_rdata;
      if (accept) begin
        lat_we    <= req_we;
        lat_ba    <= req_ba;
        lat_row   <= req_row;
        lat_col   <= req_col;
        lat_wdata <= req_wdata;
      end
      // A hit goes straight from IDLE to ACCESS, before the latches are visible.
      if (access_enter) begin
        mem_ba    <= (state_q == IDLE) ? req_ba    : lat_ba;
        mem_row   <= (state_q == IDLE) ? req_row   : lat_row;
        mem_col   <= (state_q == IDLE) ? req_col   : lat_col;
        mem_wdata <= (state_q == IDLE) ? req_wdata : lat_wdata;
      end
      if (accept && bank_open[req_ba] && !row_hit) bank_open[req_ba] <= 1'b0;
      if (act_done) begin
        bank_open[lat_ba] <= 1'b1;
        open_row[lat_ba]  <= lat_row;
      end
      if (ref_enter) bank_open <= '0;
    end
  end

`ifdef SDRAM_SCHED_REFRESH_EN
  localparam int REF_W = $clog2(REF_INTERVAL) + 1;
  logic [REF_W-1:0] ref_cnt;

  // Entering REFRESH wins over a coincident expiry: back-to-back expiries merge.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      if (ref_cnt == REF_W'(REF_INTERVAL - 1)) ref_cnt <= '0;
      else                                     ref_cnt <= ref_cnt + 1'b1;
      if (ref_enter)                                ref_pending <= 1'b0;
      else if (ref_cnt == REF_W'(REF_INTERVAL - 1)) ref_pending <= 1'b1;
    end
  end
`else
  logic unused_ref_cfg;
  assign unused_ref_cfg = (REF_INTERVAL > 0);
  assign ref_pending    = 1'b0;
`endif

endmodule
